// File: rtl/brq_mem_pkg.sv
// Shared types and default sizing for the IF/LSU memory arbiter.
package brq_mem_pkg;

  localparam int BRQ_DATA_W   = 32;
  localparam int BRQ_ADDR_W   = 15;
  localparam int BRQ_BE_W     = BRQ_DATA_W / 8;
  localparam int BRQ_MAX_WAIT = 4;

  // Requester identity, also used as the registered response owner tag.
  typedef enum logic {
    PORT_IF  = 1'b0,
    PORT_LSU = 1'b1
  } brq_port_e;

  // Fields of one memory request as presented by a requester.
  typedef struct packed {
    logic [BRQ_ADDR_W-1:0] addr;
    logic                  we;
    logic [BRQ_BE_W-1:0]   be;
    logic [BRQ_DATA_W-1:0] wdata;
  } brq_mem_req_t;

endpackage

// File: rtl/brq_mem_arbiter_if.sv
// Bundle of the two requester ports and the memory macro port around the
// arbiter. The arbiter uses the slave view; the core/memory side uses master.
interface brq_mem_arbiter_if import brq_mem_pkg::*; #(
  parameter int DataWidth = BRQ_DATA_W,
  parameter int AddrWidth = BRQ_ADDR_W
) ();

  localparam int BeWidth = DataWidth / 8;

  // Instruction-fetch requester (port 0)
  logic                 if_req_valid;
  logic [AddrWidth-1:0] if_req_addr;
  logic                 if_req_we;
  logic [BeWidth-1:0]   if_req_be;
  logic [DataWidth-1:0] if_req_wdata;
  logic                 if_req_ready;
  logic                 if_rsp_valid;
  logic [DataWidth-1:0] if_rsp_rdata;

  // Load/store requester (port 1)
  logic                 lsu_req_valid;
  logic [AddrWidth-1:0] lsu_req_addr;
  logic                 lsu_req_we;
  logic [BeWidth-1:0]   lsu_req_be;
  logic [DataWidth-1:0] lsu_req_wdata;
  logic                 lsu_req_ready;
  logic                 lsu_rsp_valid;
  logic [DataWidth-1:0] lsu_rsp_rdata;

  // Single-port memory macro
  logic                 mem_req;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_addr;
  logic [BeWidth-1:0]   mem_be;
  logic [DataWidth-1:0] mem_wdata;
  logic                 mem_gnt;
  logic [DataWidth-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_req_we, if_req_be, if_req_wdata,
    output if_req_ready, if_rsp_valid, if_rsp_rdata,
    input  lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_be, lsu_req_wdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rdata
  );

  modport master (
    output if_req_valid, if_req_addr, if_req_we, if_req_be, if_req_wdata,
    input  if_req_ready, if_rsp_valid, if_rsp_rdata,
    output lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_be, lsu_req_wdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rdata
  );

endinterface

// File: rtl/brq_arb_starve_cnt.sv
// Saturating count of consecutive cycles the fetch port lost arbitration to
// the LSU. force_if_o rises once the count reaches MaxWait so the next
// contested cycle goes to fetch.
module brq_arb_starve_cnt import brq_mem_pkg::*; #(
  parameter int MaxWait = BRQ_MAX_WAIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_valid_i,
  input  logic gnt_i,
  input  logic if_acc_i,
  input  logic lsu_acc_i,
  output logic force_if_o
);

  localparam int                  CntWidth = $clog2(MaxWait + 1);
  localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MaxWait);

  logic [CntWidth-1:0] wait_cnt_q;
  logic [CntWidth-1:0] wait_cnt_d;

  // Next count: fetch going idle wins over everything, a stalled memory
  // freezes the count, otherwise clear on a fetch grant or bump on a loss.
  always_comb begin
    // NOTE: default assignment first so every path assigns wait_cnt_d and no latch is inferred.
    wait_cnt_d = wait_cnt_q;
    if (!if_valid_i) begin
      wait_cnt_d = '0;
    end else if (!gnt_i) begin
      wait_cnt_d = wait_cnt_q;
    end else if (if_acc_i) begin
      wait_cnt_d = '0;
    end else if (lsu_acc_i && (wait_cnt_q != CntMax)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments for state so all registers update from pre-edge values.
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force_if_o = (wait_cnt_q == CntMax);

endmodule

// File: rtl/brq_mem_arbiter.sv
// Shares the single-port unified memory between instruction fetch and the
// LSU. LSU has fixed priority, fetch is guaranteed a grant after MaxWait
// consecutive losses, and every grant returns exactly one response on the
// following cycle to the port that issued it.
module brq_mem_arbiter import brq_mem_pkg::*; #(
  parameter int MaxWait = BRQ_MAX_WAIT
) (
  input logic                brq_clk,
  input logic                brq_rst,
  brq_mem_arbiter_if.slave   bus
);

  brq_mem_req_t if_req;
  brq_mem_req_t lsu_req;
  brq_mem_req_t win_req;
  brq_port_e    sel;
  logic         force_if;
  logic         accept;
  logic         if_acc;
  logic         lsu_acc;

  brq_port_e    owner_q;
  brq_port_e    owner_d;
  logic         pending_q;
  logic         pending_d;
  logic         rsp_live;

  // Starvation guard for the fetch port.
  brq_arb_starve_cnt #(
    .MaxWait (MaxWait)
  ) u_starve (
    .clk_i      (brq_clk),
    .rst_i      (brq_rst),
    .if_valid_i (bus.if_req_valid),
    .gnt_i      (bus.mem_gnt),
    .if_acc_i   (if_acc),
    .lsu_acc_i  (lsu_acc),
    .force_if_o (force_if)
  );

  // Winner selection and acceptance; held off entirely while in reset so
  // nothing reaches the memory or the pending register.
  always_comb begin
    if_req  = '{addr: bus.if_req_addr, we: bus.if_req_we,
                be: bus.if_req_be, wdata: bus.if_req_wdata};
    lsu_req = '{addr: bus.lsu_req_addr, we: bus.lsu_req_we,
                be: bus.lsu_req_be, wdata: bus.lsu_req_wdata};
    sel     = (bus.if_req_valid && (!bus.lsu_req_valid || force_if)) ? PORT_IF : PORT_LSU;
    accept  = bus.mem_gnt && (bus.if_req_valid || bus.lsu_req_valid) && !brq_rst;
    if_acc  = accept && (sel == PORT_IF);
    lsu_acc = accept && (sel == PORT_LSU);
    win_req = (sel == PORT_IF) ? if_req : lsu_req;
  end

  // Memory-side field mux; fields are zero whenever nothing is accepted.
  always_comb begin
    bus.mem_req   = accept;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    if (accept) begin
      bus.mem_we    = win_req.we;
      bus.mem_addr  = win_req.addr;
      bus.mem_be    = win_req.be;
      bus.mem_wdata = win_req.wdata;
    end
  end

  assign bus.if_req_ready  = if_acc;
  assign bus.lsu_req_ready = lsu_acc;

  // Next owner/pending: a grant this cycle owes a response next cycle.
  always_comb begin
    pending_d = accept;
    owner_d   = owner_q;
    if (accept) begin
      owner_d = sel;
    end
  end

  // Owner tag and pending bit; reset drops any response in flight.
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      pending_q <= 1'b0;
      owner_q   <= PORT_IF;
    end else begin
      pending_q <= pending_d;
      owner_q   <= owner_d;
    end
  end

  // Response routing: only the owning port sees valid and read data. A
  // response owed during a reset cycle is suppressed.
  always_comb begin
    rsp_live          = pending_q && !brq_rst;
    bus.if_rsp_valid  = rsp_live && (owner_q == PORT_IF);
    bus.lsu_rsp_valid = rsp_live && (owner_q == PORT_LSU);
    bus.if_rsp_rdata  = bus.if_rsp_valid  ? bus.mem_rdata : '0;
    bus.lsu_rsp_rdata = bus.lsu_rsp_valid ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_brq_mem_arbiter.sv
// Directed bench for brq_mem_arbiter with MaxWait = 4. Inputs change 1 ns
// after the rising edge and outputs are compared 1 ns later.
module tb_brq_mem_arbiter;

  logic brq_clk = 1'b0;
  logic brq_rst;
  int   checks = 0;
  int   errors = 0;

  brq_mem_arbiter_if bus ();

  brq_mem_arbiter #(
    .MaxWait (4)
  ) dut (
    .brq_clk (brq_clk),
    .brq_rst (brq_rst),
    .bus     (bus)
  );

  always #5 brq_clk = ~brq_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge brq_clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req_valid  = 1'b0;
    bus.if_req_addr   = '0;
    bus.if_req_we     = 1'b0;
    bus.if_req_be     = '0;
    bus.if_req_wdata  = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_addr  = '0;
    bus.lsu_req_we    = 1'b0;
    bus.lsu_req_be    = '0;
    bus.lsu_req_wdata = '0;
  endtask

  task automatic drive_if(input logic [14:0] addr);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = addr;
    bus.if_req_we    = 1'b0;
    bus.if_req_be    = 4'hF;
    bus.if_req_wdata = '0;
  endtask

  task automatic drive_lsu(input logic [14:0] addr, input logic we, input logic [31:0] wdata);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = addr;
    bus.lsu_req_we    = we;
    bus.lsu_req_be    = 4'hF;
    bus.lsu_req_wdata = wdata;
  endtask

  initial begin
    // Reset with both requesters valid: every output must stay 0.
    brq_rst       = 1'b1;
    idle();
    bus.mem_gnt   = 1'b1;
    bus.mem_rdata = '0;
    drive_if(15'h0010);
    drive_lsu(15'h0020, 1'b1, 32'h1);
    tick();
    tick();
    #1;
    check("rst_if_ready",  bus.if_req_ready, 1'b0);
    check("rst_lsu_ready", bus.lsu_req_ready, 1'b0);
    check("rst_mem_req",   bus.mem_req, 1'b0);
    check("rst_mem_we",    bus.mem_we, 1'b0);
    check("rst_mem_addr",  bus.mem_addr, 15'h0);
    check("rst_if_rsp",    bus.if_rsp_valid, 1'b0);
    check("rst_lsu_rsp",   bus.lsu_rsp_valid, 1'b0);
    check("rst_wait_cnt",  dut.u_starve.wait_cnt_q, 3'd0);
    brq_rst = 1'b0;
    idle();
    tick();

    // IF-only read of 0x0010, memory returns 0xDEADBEEF next cycle.
    drive_if(15'h0010);
    #1;
    check("t1_if_ready",  bus.if_req_ready, 1'b1);
    check("t1_lsu_ready", bus.lsu_req_ready, 1'b0);
    check("t1_mem_req",   bus.mem_req, 1'b1);
    check("t1_mem_we",    bus.mem_we, 1'b0);
    check("t1_mem_addr",  bus.mem_addr, 15'h0010);
    tick();
    idle();
    bus.mem_rdata = 32'hDEADBEEF;
    #1;
    check("t1_if_rsp",    bus.if_rsp_valid, 1'b1);
    check("t1_if_rdata",  bus.if_rsp_rdata, 32'hDEADBEEF);
    check("t1_lsu_rsp",   bus.lsu_rsp_valid, 1'b0);
    check("t1_mem_idle",  bus.mem_req, 1'b0);
    tick();

    // Both valid: LSU write of 0x12345678 to 0x0020 wins, IF follows.
    drive_if(15'h0030);
    drive_lsu(15'h0020, 1'b1, 32'h12345678);
    #1;
    check("t2_lsu_ready", bus.lsu_req_ready, 1'b1);
    check("t2_if_ready",  bus.if_req_ready, 1'b0);
    check("t2_mem_we",    bus.mem_we, 1'b1);
    check("t2_mem_addr",  bus.mem_addr, 15'h0020);
    check("t2_mem_wdata", bus.mem_wdata, 32'h12345678);
    check("t2_mem_be",    bus.mem_be, 4'hF);
    tick();
    bus.lsu_req_valid = 1'b0;
    #1;
    check("t2_lsu_ack",   bus.lsu_rsp_valid, 1'b1);
    check("t2_if_rsp0",   bus.if_rsp_valid, 1'b0);
    check("t2_wait1",     dut.u_starve.wait_cnt_q, 3'd1);
    check("t2_if_ready",  bus.if_req_ready, 1'b1);
    check("t2_if_addr",   bus.mem_addr, 15'h0030);
    tick();
    idle();
    bus.mem_rdata = 32'h0BADF00D;
    #1;
    check("t2_if_rsp",    bus.if_rsp_valid, 1'b1);
    check("t2_if_rdata",  bus.if_rsp_rdata, 32'h0BADF00D);
    check("t2_wait0",     dut.u_starve.wait_cnt_q, 3'd0);
    tick();

    // Starvation: LSU every cycle, IF held at 0x0040. LSU wins four times,
    // IF the fifth, then LSU resumes with the counter back at 0.
    for (int k = 0; k <= 5; k++) begin
      idle();
      if (k <= 4) drive_if(15'h0040);
      drive_lsu(15'(256 + k), 1'b0, 32'h0);
      #1;
      check("t3_wait_cnt",  dut.u_starve.wait_cnt_q, (k <= 4) ? k : 0);
      check("t3_if_ready",  bus.if_req_ready, k == 4);
      check("t3_lsu_ready", bus.lsu_req_ready, k != 4);
      check("t3_mem_addr",  bus.mem_addr, (k == 4) ? 15'h0040 : 15'(256 + k));
      if (k > 0) begin
        check("t3_lsu_rsp", bus.lsu_rsp_valid, k != 5);
        check("t3_if_rsp",  bus.if_rsp_valid, k == 5);
      end
      tick();
    end
    idle();
    #1;
    check("t3_lsu_last",  bus.lsu_rsp_valid, 1'b1);
    tick();

    // mem_gnt low for three cycles with both valid and wait_cnt at 2.
    drive_if(15'h0048);
    drive_lsu(15'h0200, 1'b0, 32'h0);
    #1;
    check("t4_lsu_win_a", bus.lsu_req_ready, 1'b1);
    tick();
    drive_lsu(15'h0201, 1'b0, 32'h0);
    #1;
    check("t4_wait_b",    dut.u_starve.wait_cnt_q, 3'd1);
    check("t4_lsu_win_b", bus.lsu_req_ready, 1'b1);
    tick();
    drive_lsu(15'h0202, 1'b0, 32'h0);
    bus.mem_gnt = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      check("t4_if_ready",  bus.if_req_ready, 1'b0);
      check("t4_lsu_ready", bus.lsu_req_ready, 1'b0);
      check("t4_mem_req",   bus.mem_req, 1'b0);
      check("t4_wait_hold", dut.u_starve.wait_cnt_q, 3'd2);
      check("t4_lsu_rsp",   bus.lsu_rsp_valid, j == 0);
      tick();
    end
    bus.mem_gnt = 1'b1;
    #1;
    check("t4_resume",    bus.lsu_req_ready, 1'b1);
    check("t4_wait_res",  dut.u_starve.wait_cnt_q, 3'd2);
    check("t4_res_addr",  bus.mem_addr, 15'h0202);
    check("t4_no_rsp",    bus.lsu_rsp_valid, 1'b0);
    tick();
    idle();
    #1;
    check("t4_lsu_ack",   bus.lsu_rsp_valid, 1'b1);
    check("t4_wait3",     dut.u_starve.wait_cnt_q, 3'd3);
    tick();
    #1;
    check("t4_wait_clr",  dut.u_starve.wait_cnt_q, 3'd0);
    tick();

    // Alternating IF/LSU reads every cycle; responses one cycle behind.
    for (int i = 0; i <= 4; i++) begin
      idle();
      if (i < 4) begin
        if (i % 2 == 0) drive_if(15'(80 + i));
        else drive_lsu(15'(96 + i), 1'b0, 32'h0);
      end
      if (i > 0) bus.mem_rdata = 32'hA000_0000 + 32'(i - 1);
      #1;
      if (i < 4) begin
        check("t5_if_ready",  bus.if_req_ready, i % 2 == 0);
        check("t5_lsu_ready", bus.lsu_req_ready, i % 2 == 1);
      end
      if (i > 0) begin
        check("t5_if_rsp",  bus.if_rsp_valid, (i - 1) % 2 == 0);
        check("t5_lsu_rsp", bus.lsu_rsp_valid, (i - 1) % 2 == 1);
        if ((i - 1) % 2 == 0) check("t5_if_rdata", bus.if_rsp_rdata, 32'hA000_0000 + 32'(i - 1));
        else check("t5_lsu_rdata", bus.lsu_rsp_rdata, 32'hA000_0000 + 32'(i - 1));
      end
      tick();
    end

    // Reset for one cycle right after a grant drops the owed response.
    drive_lsu(15'h0070, 1'b0, 32'h0);
    #1;
    check("t6_lsu_ready", bus.lsu_req_ready, 1'b1);
    tick();
    brq_rst = 1'b1;
    idle();
    drive_if(15'h0080);
    bus.mem_rdata = 32'h55555555;
    #1;
    check("t6_rst_lsu_rsp",   bus.lsu_rsp_valid, 1'b0);
    check("t6_rst_lsu_rdata", bus.lsu_rsp_rdata, 32'h0);
    check("t6_rst_if_rsp",    bus.if_rsp_valid, 1'b0);
    check("t6_rst_if_ready",  bus.if_req_ready, 1'b0);
    check("t6_rst_mem_req",   bus.mem_req, 1'b0);
    tick();
    brq_rst = 1'b0;
    idle();
    #1;
    check("t6_post_lsu_rsp",  bus.lsu_rsp_valid, 1'b0);
    check("t6_post_if_rsp",   bus.if_rsp_valid, 1'b0);
    tick();
    drive_if(15'h0080);
    #1;
    check("t6_if_ready",  bus.if_req_ready, 1'b1);
    check("t6_mem_addr",  bus.mem_addr, 15'h0080);
    tick();
    idle();
    bus.mem_rdata = 32'hCAFEF00D;
    #1;
    check("t6_if_rsp",    bus.if_rsp_valid, 1'b1);
    check("t6_if_rdata",  bus.if_rsp_rdata, 32'hCAFEF00D);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
